// File: rtl/generador_secuencia.sv
// generador_secuencia
// Builds a sequence of NUM_NOTAS 3-bit notes, taken from a free-running
// 16-bit Fibonacci LFSR. Code 000 means "no note" and is never stored.
// The sequence is collected in a shadow register and copied to busNotas in
// one step when the last note is written. busNotas therefore never holds a
// partial sequence.
//
// Ports
//   clk             clock; all state changes happen on the rising edge
//   reset           synchronous, active-high reset
//   cargarSecuencia request for a new sequence (level-sampled)
//   finJuego        game over: aborts generation or leaves LISTO
//   busNotas        packed sequence, note k in [3k+2:3k], note 0 is played first
//   datoListo       high while the FSM is in LISTO
//   ocupado         high while the FSM is in GEN
//   contador        number of notes accepted in the current generation
module generador_secuencia #(
    parameter int unsigned NUM_NOTAS = 10,
    parameter logic [15:0] SEMILLA   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cargarSecuencia,
    input  logic                   finJuego,
    output logic [3*NUM_NOTAS-1:0] busNotas,
    output logic                   datoListo,
    output logic                   ocupado,
    output logic [3:0]             contador
);

    localparam logic [3:0] ULTIMA = 4'(NUM_NOTAS - 1);
    localparam logic [3:0] MAXIMO = 4'(NUM_NOTAS);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        LISTO
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [3*NUM_NOTAS-1:0] sombra_q, sombra_d;
    logic [3*NUM_NOTAS-1:0] bus_q, bus_d;
    logic [3:0]             contador_q, contador_d;
    logic                   listo_q, listo_d;
    logic                   ocupado_q, ocupado_d;

    // A note is accepted in GEN only when the low LFSR bits are non-zero.
    logic nota_valida;
    assign nota_valida = (lfsr_q[2:0] != 3'b000);

    // The LFSR runs in every state. Only reset reloads it.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= IDLE;
            lfsr_q     <= SEMILLA;
            sombra_q   <= '0;
            bus_q      <= '0;
            contador_q <= '0;
            listo_q    <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            lfsr_q     <= lfsr_d;
            sombra_q   <= sombra_d;
            bus_q      <= bus_d;
            contador_q <= contador_d;
            listo_q    <= listo_d;
            ocupado_q  <= ocupado_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            IDLE: begin
                if (cargarSecuencia) begin
                    estado_d = GEN;
                end
            end
            GEN: begin
                if (finJuego) begin
                    estado_d = IDLE;
                end else if (nota_valida && contador_q == ULTIMA) begin
                    estado_d = LISTO;
                end
            end
            LISTO: begin
                // finJuego has priority over a new request.
                if (finJuego) begin
                    estado_d = IDLE;
                end else if (cargarSecuencia) begin
                    estado_d = GEN;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        sombra_d   = sombra_q;
        bus_d      = bus_q;
        contador_d = contador_q;
        listo_d    = (estado_d == LISTO);
        ocupado_d  = (estado_d == GEN);

        unique case (estado_q)
            IDLE: begin
                if (cargarSecuencia) begin
                    sombra_d   = '0;
                    contador_d = '0;
                end
            end
            GEN: begin
                if (finJuego) begin
                    sombra_d   = '0;
                    contador_d = '0;
                end else if (nota_valida && contador_q < MAXIMO) begin
                    for (int unsigned k = 0; k < NUM_NOTAS; k++) begin
                        if (contador_q == 4'(k)) begin
                            sombra_d[3*k +: 3] = lfsr_q[2:0];
                        end
                    end
                    contador_d = contador_q + 4'd1;
                    // Publish the shadow together with the note written on
                    // this edge, so the bus changes in one step.
                    if (contador_q == ULTIMA) begin
                        bus_d = sombra_d;
                    end
                end
            end
            LISTO: begin
                if (!finJuego && cargarSecuencia) begin
                    sombra_d   = '0;
                    contador_d = '0;
                end
            end
            default: begin
                sombra_d   = '0;
                contador_d = '0;
            end
        endcase
    end

    assign busNotas  = bus_q;
    assign datoListo = listo_q;
    assign ocupado   = ocupado_q;
    assign contador  = contador_q;

endmodule
